// File: rtl/mod_mult_interleaved_if.sv
// Request/result bundle between the exponentiator (master) and the modular multiplier (slave).
interface mod_mult_interleaved_if #(
   parameter int BUS_WIDTH = 256
);
   logic [BUS_WIDTH-1:0] a;
   logic [BUS_WIDTH-1:0] b;
   logic [BUS_WIDTH-1:0] n;
   logic                 ready;
   logic [BUS_WIDTH-1:0] out;
   logic                 valid;
   logic                 busy;

   modport master (output a, b, n, ready, input out, valid, busy);
   modport slave  (input a, b, n, ready, output out, valid, busy);
endinterface

// File: rtl/mod_mult_interleaved.sv
// Interleaved shift-add-reduce modular multiplier: out = (a * b) mod n,
// scanning b MSB first, one bit per clock.
module mod_mult_interleaved #(
   parameter int BUS_WIDTH     = 256,
   parameter int COUNTER_WIDTH = 8
) (
   input logic                clk,
   input logic                reset,
   mod_mult_interleaved_if.slave bus
);
   localparam int PW = BUS_WIDTH + 2;
   localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(BUS_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                   state_reg;
   logic [BUS_WIDTH-1:0]     a_reg;
   logic [BUS_WIDTH-1:0]     b_reg;
   logic [BUS_WIDTH-1:0]     n_reg;
   logic [BUS_WIDTH-1:0]     out_reg;
   logic [PW-1:0]            p_reg;
   logic [COUNTER_WIDTH-1:0] idx_reg;
   logic                     valid_reg;
   logic                     busy_reg;

   logic [PW-1:0] n_ext;
   logic [PW-1:0] addend;
   logic [PW-1:0] t_sum;
   logic [PW-1:0] t_once;
   logic [PW-1:0] p_next;

   // With P < N and A < N, 2P + A < 3N, so two conditional subtracts always
   // bring the sum back below N. Two guard bits keep 2P + A from overflowing.
   always_comb begin
      n_ext  = {2'b00, n_reg};
      addend = b_reg[idx_reg] ? {2'b00, a_reg} : '0;
      t_sum  = {p_reg[PW-2:0], 1'b0} + addend;
      t_once = (t_sum >= n_ext) ? t_sum - n_ext : t_sum;
      p_next = (t_once >= n_ext) ? t_once - n_ext : t_once;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         n_reg     <= '0;
         p_reg     <= '0;
         idx_reg   <= '0;
         out_reg   <= '0;
         valid_reg <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.ready) begin
                  if (bus.n != '0) begin
                     a_reg     <= bus.a;
                     b_reg     <= bus.b;
                     n_reg     <= bus.n;
                     p_reg     <= '0;
                     idx_reg   <= LAST_IDX;
                     busy_reg  <= 1'b1;
                     state_reg <= BUSY;
                  end else begin
                     // Zero modulus short-circuits straight to a zero result.
                     out_reg   <= '0;
                     valid_reg <= 1'b1;
                     state_reg <= DONE;
                  end
               end
            end
            BUSY: begin
               p_reg <= p_next;
               if (idx_reg == '0) begin
                  out_reg   <= p_next[BUS_WIDTH-1:0];
                  valid_reg <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= DONE;
               end else begin
                  idx_reg <= idx_reg - 1'b1;
               end
            end
            DONE: begin
               // Hold the result until the requester drops ready.
               if (!bus.ready) begin
                  valid_reg <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.out   = out_reg;
   assign bus.valid = valid_reg;
   assign bus.busy  = busy_reg;
endmodule

// File: tb/tb_mod_mult_interleaved.sv
// Self-checking bench for mod_mult_interleaved: directed table, corner sequences, random sweep.
module tb_mod_mult_interleaved;
   localparam int BW = 256;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mod_mult_interleaved_if #(.BUS_WIDTH(BW)) bus ();

   mod_mult_interleaved #(.BUS_WIDTH(BW), .COUNTER_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string          name;
      logic [BW-1:0]  a;
      logic [BW-1:0]  b;
      logic [BW-1:0]  n;
      logic [BW-1:0]  exp_out;
      bit             pulse;
      int             hold;
   } vec_t;

   vec_t table_v[5];

   function automatic logic [BW-1:0] rand256();
      logic [BW-1:0] r;
      for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference: plain wide arithmetic on a double-width product.
   function automatic logic [BW-1:0] ref_modmul(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                                input logic [BW-1:0] n);
      logic [2*BW-1:0] prod;
      logic [2*BW-1:0] r;
      if (n == '0) return '0;
      prod = {{BW{1'b0}}, a} * {{BW{1'b0}}, b};
      r = prod % {{BW{1'b0}}, n};
      return r[BW-1:0];
   endfunction

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_op(input string name, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic [BW-1:0] n, input logic [BW-1:0] exp_out,
                         input bit pulse, input int hold);
      int lat;
      int busy_cnt;
      int exp_lat;
      exp_lat = (n == '0) ? 0 : BW;
      @(negedge clk);
      bus.a = a; bus.b = b; bus.n = n; bus.ready = 1'b1;
      @(negedge clk);
      // Capture has happened; later input changes must be ignored.
      bus.a = rand256(); bus.b = rand256(); bus.n = rand256();
      if (pulse) bus.ready = 1'b0;
      lat = 0;
      busy_cnt = 0;
      while (!bus.valid && lat < 400) begin
         if (bus.busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, BW'(lat), BW'(exp_lat));
      check({name, " busy cycles"}, BW'(busy_cnt), BW'(exp_lat));
      check({name, " out"}, bus.out, exp_out);
      check({name, " busy after done"}, BW'(bus.busy), '0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({name, " valid held"}, BW'(bus.valid), BW'(1));
         check({name, " no restart"}, BW'(bus.busy), '0);
      end
      bus.ready = 1'b0;
      @(negedge clk);
      check({name, " valid drop"}, BW'(bus.valid), '0);
      check({name, " out hold"}, bus.out, exp_out);
      if (pulse) begin
         repeat (3) @(negedge clk);
         check({name, " out hold idle"}, bus.out, exp_out);
      end
   endtask

   initial begin
      logic [BW-1:0] big_n;
      logic [BW-1:0] ra, rb, rn;
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.a = '0; bus.b = '0; bus.n = '0; bus.ready = 1'b0;

      big_n = '0;
      big_n[BW-1] = 1'b1;
      table_v[0] = '{"hold7x9", BW'(7), BW'(9), BW'(13), BW'(11), 1'b0, 6};
      table_v[1] = '{"wide", big_n - 1, big_n - 1, big_n, BW'(1), 1'b0, 0};
      table_v[2] = '{"nzero", BW'(5), BW'(6), BW'(0), BW'(0), 1'b0, 2};
      table_v[3] = '{"pulse", BW'(123456789), BW'(987654321), BW'(1000000007),
                     BW'(259106859), 1'b1, 0};
      table_v[4] = '{"n1", BW'(0), BW'(0), BW'(1), BW'(0), 1'b0, 0};

      @(negedge clk);
      check("reset out", bus.out, '0);
      check("reset valid", BW'(bus.valid), '0);
      check("reset busy", BW'(bus.busy), '0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++)
         run_op(table_v[i].name, table_v[i].a, table_v[i].b, table_v[i].n,
                table_v[i].exp_out, table_v[i].pulse, table_v[i].hold);
      // Leave a nonzero result in out before the reset sequence.
      run_op("pre_reset", BW'(3), BW'(4), BW'(11), BW'(1), 1'b0, 0);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      bus.a = BW'(10); bus.b = BW'(20); bus.n = BW'(23); bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
      repeat (100) @(negedge clk);
      check("midbusy busy", BW'(bus.busy), BW'(1));
      #2 reset = 1'b1;
      #1;
      check("async rst busy", BW'(bus.busy), '0);
      check("async rst valid", BW'(bus.valid), '0);
      check("async rst out", bus.out, '0);
      @(negedge clk);
      reset = 1'b0;
      run_op("after_reset", BW'(3), BW'(5), BW'(7), BW'(1), 1'b0, 0);

      // Random sweep against the reference model.
      for (int v = 0; v < 150; v++) begin
         rn = rand256();
         if (v % 3 == 0) rn[BW-1] = 1'b1;
         else rn = rn >> $urandom_range(0, BW - 8);
         if (rn < 2) rn = BW'(2);
         ra = rand256() % rn;
         rb = rand256() % rn;
         run_op($sformatf("rand%0d", v), ra, rb, rn, ref_modmul(ra, rb, rn), 1'b0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
